// File: rtl/gray_tx_pkg.sv
// Shared types, sizing constants and the BCD-to-Gray helper for the Gray digit transmitter.
package gray_tx_pkg;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned DIG_W  = 4;
    localparam int unsigned BCD_W  = DIGITS * DIG_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [DIG_W-1:0] bin2gray(input logic [DIG_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/module_gray_tx_bin2gray.sv
// Combinational 4-bit binary-to-Gray encoder.
module module_bin2gray
    import gray_tx_pkg::*;
(
    input  logic [DIG_W-1:0] bin_i,
    output logic [DIG_W-1:0] gray_o
);

    assign gray_o = bin2gray(bin_i);

endmodule

// File: rtl/module_gray_tx.sv
// Sends up to four BCD digits as held Gray codes separated by idle gaps, MS selected digit first.
module module_gray_tx
    import gray_tx_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 27000,
    parameter int unsigned GAP_CYCLES  = 2700
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bcd_in,
    input  logic [2:0]  num_digits,
    output logic        ag,
    output logic        bg,
    output logic        cg,
    output logic        dg,
    output logic        dig_valid,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int unsigned REM_W   = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [BCD_W-1:0]   shift_q, shift_d;
    logic [DIG_W-1:0]   code_q, code_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               req_ok_c;
    logic [BCD_W-1:0]   aligned_c;
    logic [DIG_W-1:0]   gray_c;

    // Request is legal only with 1..4 digits and every selected digit a valid BCD value
    always_comb begin
        req_ok_c = (num_digits >= 3'd1) && (num_digits <= 3'(DIGITS));
        for (int i = 0; i < int'(DIGITS); i++) begin
            if ((i < int'(num_digits)) && (bcd_in[i*DIG_W +: DIG_W] > 4'd9)) begin
                req_ok_c = 1'b0;
            end
        end
    end

    // Left-align the selected digits so the next one to send is always in the top nibble
    always_comb begin
        case (num_digits)
            3'd1:    aligned_c = {bcd_in[3:0],  12'h000};
            3'd2:    aligned_c = {bcd_in[7:0],  8'h00};
            3'd3:    aligned_c = {bcd_in[11:0], 4'h0};
            default: aligned_c = bcd_in;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            shift_q <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            shift_q <= shift_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next state; the counter is reloaded on every state entry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (start && req_ok_c) begin
                    state_d = ST_SEND;
                    cnt_d   = HOLD_LOAD;
                    rem_d   = REM_W'(num_digits - 3'd1);
                    shift_d = aligned_c;
                end
            end
            ST_SEND: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    if (rem_q != '0) begin
                        state_d = ST_SEND;
                        cnt_d   = HOLD_LOAD;
                        rem_d   = rem_q - REM_W'(1);
                        shift_d = shift_q << DIG_W;
                    end else begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    module_bin2gray u_bin2gray (
        .bin_i  (shift_d[BCD_W-1 -: DIG_W]),
        .gray_o (gray_c)
    );

    // Output values are derived from the upcoming state so they line up with state_q
    always_comb begin
        code_d  = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (state_d == ST_SEND) begin
            code_d  = gray_c;
            valid_d = 1'b1;
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        err_d  = (state_q == ST_IDLE) && start && !req_ok_c;
    end

    assign {ag, bg, cg, dg} = code_q;
    assign dig_valid        = valid_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign err              = err_q;

endmodule

// File: doc/module_gray_tx.md
MODULE_GRAY_TX -- requirements
Module: module_gray_tx

Interface
REQ-001 Parameter HOLD_CYCLES, default 27000, is the cycles each digit code is held valid (1 ms at 27 MHz).
REQ-002 Parameter GAP_CYCLES, default 2700, is the idle cycles between consecutive digits.
REQ-003 clk  input  1  system clock, 27 MHz nominal.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 start  input  1  request to send the loaded number; level-sampled in IDLE only.
REQ-006 bcd_in  input  16  four BCD digits: [15:12] milesimas, [11:8] centenas, [7:4] decenas, [3:0] unidades.
REQ-007 num_digits  input  3  count of least-significant digits to send; legal range 1..4.
REQ-008 ag, bg, cg, dg  output  1 each  Gray code of the current digit; ag is the MSB.
REQ-009 dig_valid  output  1  high while ag..dg carry a valid digit code.
REQ-010 busy  output  1  high from the cycle after accepted start through DONE.
REQ-011 done  output  1  one-cycle pulse after the last digit's gap.
REQ-012 err  output  1  one-cycle pulse when a start request is rejected.

Function
REQ-013 FSM states: IDLE, SEND, GAP, DONE.
REQ-014 IDLE: start=1 with legal num_digits and all selected digits <=9 -> latch bcd_in and num_digits, go to SEND; the first code appears on the next cycle.
REQ-015 IDLE: start=1 with num_digits 0 or >4, or any selected digit >9 -> err=1 for one cycle, remain in IDLE, latch nothing.
REQ-016 Digits are sent most-significant selected digit first; unselected upper digits are never sent.
REQ-017 Gray encoding: {ag,bg,cg,dg} = b ^ (b >> 1), where b is the 4-bit BCD digit.
REQ-018 SEND: drive the digit code with dig_valid=1 for exactly HOLD_CYCLES cycles, then go to GAP.
REQ-019 GAP: drive ag..dg=0000 with dig_valid=0 for exactly GAP_CYCLES cycles.
REQ-020 GAP exit: go to SEND with the next digit if digits remain, otherwise go to DONE.
REQ-021 DONE: done=1 and busy=1 for one cycle, then go to IDLE.
REQ-022 Sequence length: start accepted at cycle 0 gives done at cycle 1 + num_digits*(HOLD_CYCLES+GAP_CYCLES).
REQ-023 start asserted outside IDLE is ignored; bcd_in changes after acceptance do not affect the sequence in flight.
REQ-024 start held high through DONE begins a new sequence on the first IDLE cycle.
REQ-025 All outputs are registered; no combinational path from any input to any output.
REQ-026 The hold/gap counter is sized $clog2(max(HOLD_CYCLES,GAP_CYCLES))+1 bits and is reloaded on every state entry, so it never wraps.

Reset
REQ-027 When rst is asserted, including mid-sequence: state=IDLE; ag..dg=0000; dig_valid, busy, done and err are 0; counters and latched data are cleared.
REQ-028 After rst is released, the first start is accepted on the first clk edge.

Structure
REQ-029 Package gray_tx_pkg holds the state enum, the DIGITS=4 constant, and the bin2gray function.
REQ-030 One sub-module, module_bin2gray (4-bit combinational encoder), is instantiated once at the shift-register output, ahead of the output register.

Verification
REQ-031 HOLD=4, GAP=2, bcd_in=16'h0123, num_digits=3, one-cycle start -> codes 0001, 0011, 0010 at cycles 1-4, 7-10 and 13-16; done at cycle 19.
REQ-032 bcd_in=16'h9740, num_digits=4 -> code sequence 1101, 0100, 0110, 0000, each with dig_valid high for HOLD cycles.
REQ-033 bcd_in=16'h00A5, num_digits=2 -> err pulse, busy stays 0, no dig_valid; repeat with num_digits=0 -> err pulse.
REQ-034 Pulse start while busy, then change bcd_in mid-sequence -> sequence unchanged, single done pulse.
REQ-035 Assert rst during the second SEND -> all outputs 0 asynchronously; a new start after release runs a full sequence.
REQ-036 Hold start high continuously with num_digits=1 -> back-to-back sequences with exactly one IDLE cycle between DONE and the next SEND.
